// File: rtl/instruction_fetch_if.sv
// Fetch-side bus bundle: instruction memory port, decode handshake and execute redirect.
// master = fetch unit, slave = the memory/decode/execute environment around it.
interface instruction_fetch_if;
    logic [31:0] PC;
    logic [31:0] instruction;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;

    modport master (
        output PC, if_valid, if_instruction, if_pc, halted,
        input  instruction, if_ready, redirect, redirect_pc
    );

    modport slave (
        input  PC, if_valid, if_instruction, if_pc, halted,
        output instruction, if_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: reads the word at PC, buffers {instruction, PC} in a small FIFO for decode,
// honours execute redirects and stops on the all-zero end-of-program word.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    instruction_fetch_if.master bus
);
    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(QUEUE_DEPTH);

    typedef enum logic [0:0] {StFetch, StHalted} state_e;

    state_e              state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]       count_q, count_d;
    logic [31:0]         instr_mem_q [QUEUE_DEPTH];
    logic [31:0]         pc_mem_q    [QUEUE_DEPTH];
    logic                pop, push, enq;
    logic                unused_redirect_lsb;

    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    always_comb begin
        pop      = (count_q != '0) && bus.if_ready;
        push     = (state_q == StFetch) && !bus.redirect && ((count_q < DepthCnt) || pop);
        enq      = push && (bus.instruction != 32'h0);
        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (bus.redirect) begin
            // Flush wins over any push/pop this cycle; a pop handshake is still consumed by decode.
            state_d  = StFetch;
            pc_d     = {bus.redirect_pc[31:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                if (enq) begin
                    pc_d = pc_q + 32'd4;
                end else begin
                    state_d = StHalted;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            unique case ({enq, pop})
                2'b10:   count_d = count_q + (PtrW + 1)'(1);
                2'b01:   count_d = count_q - (PtrW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StFetch;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is cleared on reset so the head outputs read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                instr_mem_q[i] <= 32'h0;
                pc_mem_q[i]    <= 32'h0;
            end
        end else if (enq) begin
            instr_mem_q[wr_ptr_q] <= bus.instruction;
            pc_mem_q[wr_ptr_q]    <= pc_q;
        end
    end

    assign bus.PC             = pc_q;
    assign bus.if_valid       = (count_q != '0);
    assign bus.if_instruction = instr_mem_q[rd_ptr_q];
    assign bus.if_pc          = pc_mem_q[rd_ptr_q];
    assign bus.halted         = (state_q == StHalted);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: scoreboard of expected {instruction, pc} pairs checked
// at each decode handshake, plus point checks of reset, backpressure, redirect and wrap-around.
module tb_instruction_fetch;
    logic clk;
    logic rst_na;
    logic rst_nb;
    int   n_cmp;
    int   n_err;
    logic [63:0] exp_q [$];

    instruction_fetch_if bus_a ();
    instruction_fetch_if bus_b ();

    instruction_fetch #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (2)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_na),
        .bus   (bus_a)
    );

    instruction_fetch #(
        .RESET_PC    (32'hFFFF_FFFC),
        .QUEUE_DEPTH (2)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_nb),
        .bus   (bus_b)
    );

    function automatic logic [31:0] imem_a(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hF841_4281;
            32'h0000_0004: return 32'h8B01_0022;
            32'h0000_0008: return 32'hD100_6733;
            32'h0000_000C: return 32'hB400_00E3;
            default:       return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] imem_b(input logic [31:0] a);
        case (a)
            32'hFFFF_FFFC: return 32'h1111_1111;
            32'h0000_0000: return 32'h2222_2222;
            default:       return 32'h0;
        endcase
    endfunction

    assign bus_a.instruction = imem_a(bus_a.PC);
    assign bus_b.instruction = imem_b(bus_b.PC);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Score any handshake that the coming edge will complete, then advance one cycle.
    task automatic tick();
        if (bus_a.if_valid && bus_a.if_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL unexpected_pop: observed pc %h expected no entry", bus_a.if_pc);
            end else begin
                chk("scoreboard", {bus_a.if_instruction, bus_a.if_pc}, exp_q.pop_front());
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_prog();
        exp_q.push_back({32'hF841_4281, 32'h0000_0000});
        exp_q.push_back({32'h8B01_0022, 32'h0000_0004});
        exp_q.push_back({32'hD100_6733, 32'h0000_0008});
        exp_q.push_back({32'hB400_00E3, 32'h0000_000C});
    endtask

    task automatic reset_a();
        rst_na = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_na = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_na = 1'b0;
        rst_nb = 1'b0;
        bus_a.if_ready = 1'b0;
        bus_a.redirect = 1'b0;
        bus_a.redirect_pc = 32'h0;
        bus_b.if_ready = 1'b0;
        bus_b.redirect = 1'b0;
        bus_b.redirect_pc = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_valid", bus_a.if_valid, 1'b0);
        chk("reset_pc", bus_a.PC, 32'h0);
        chk("reset_if_instr", bus_a.if_instruction, 32'h0);
        chk("reset_if_pc", bus_a.if_pc, 32'h0);
        chk("reset_halted", bus_a.halted, 1'b0);
        chk("reset_pc_b", bus_b.PC, 32'hFFFF_FFFC);

        // Straight-line run with decode always ready.
        rst_na = 1'b1;
        bus_a.if_ready = 1'b1;
        push_prog();
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 4) begin
                chk("run_valid", bus_a.if_valid, 1'b1);
                chk("run_if_pc", bus_a.if_pc, 32'(4 * (c - 1)));
            end
        end
        chk("run_halted", bus_a.halted, 1'b1);
        chk("run_pc_hold", bus_a.PC, 32'h10);
        chk("run_drained", 64'(exp_q.size()), 64'd0);

        // Redirect out of HALTED.
        bus_a.redirect = 1'b1;
        bus_a.redirect_pc = 32'h4;
        tick();
        bus_a.redirect = 1'b0;
        exp_q.delete();
        chk("rdh_halted", bus_a.halted, 1'b0);
        chk("rdh_pc", bus_a.PC, 32'h4);
        chk("rdh_valid", bus_a.if_valid, 1'b0);
        exp_q.push_back({32'h8B01_0022, 32'h0000_0004});
        exp_q.push_back({32'hD100_6733, 32'h0000_0008});
        exp_q.push_back({32'hB400_00E3, 32'h0000_000C});
        tick();
        chk("rdh_first_valid", bus_a.if_valid, 1'b1);
        chk("rdh_first_pc", bus_a.if_pc, 32'h4);
        for (int c = 0; c < 5; c++) tick();
        chk("rdh_rehalt", bus_a.halted, 1'b1);
        chk("rdh_drained", 64'(exp_q.size()), 64'd0);

        // Backpressure: queue fills, PC holds, order preserved on release.
        bus_a.if_ready = 1'b0;
        reset_a();
        push_prog();
        for (int c = 0; c < 5; c++) tick();
        chk("bp_pc_hold", bus_a.PC, 32'h8);
        chk("bp_valid", bus_a.if_valid, 1'b1);
        chk("bp_head_instr", bus_a.if_instruction, 32'hF841_4281);
        chk("bp_head_pc", bus_a.if_pc, 32'h0);
        bus_a.if_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        chk("bp_halted", bus_a.halted, 1'b1);

        // Redirect with a full queue; target LSBs are dropped.
        bus_a.if_ready = 1'b0;
        reset_a();
        for (int c = 0; c < 3; c++) tick();
        chk("rdf_pc_full", bus_a.PC, 32'h8);
        bus_a.redirect = 1'b1;
        bus_a.redirect_pc = 32'h0000_000E;
        tick();
        bus_a.redirect = 1'b0;
        exp_q.delete();
        chk("rdf_flush_valid", bus_a.if_valid, 1'b0);
        chk("rdf_pc", bus_a.PC, 32'hC);
        exp_q.push_back({32'hB400_00E3, 32'h0000_000C});
        bus_a.if_ready = 1'b1;
        tick();
        chk("rdf_first_valid", bus_a.if_valid, 1'b1);
        chk("rdf_first_pc", bus_a.if_pc, 32'hC);
        for (int c = 0; c < 4; c++) tick();
        chk("rdf_drained", 64'(exp_q.size()), 64'd0);
        chk("rdf_halted", bus_a.halted, 1'b1);

        // Asynchronous reset between edges with two entries queued.
        bus_a.if_ready = 1'b0;
        reset_a();
        for (int c = 0; c < 3; c++) tick();
        chk("ar_valid_before", bus_a.if_valid, 1'b1);
        #2;
        rst_na = 1'b0;
        #1;
        chk("ar_valid_now", bus_a.if_valid, 1'b0);
        chk("ar_pc_now", bus_a.PC, 32'h0);
        @(negedge clk);
        rst_na = 1'b1;
        exp_q.delete();
        push_prog();
        bus_a.if_ready = 1'b1;
        tick();
        chk("ar_restart_valid", bus_a.if_valid, 1'b1);
        chk("ar_restart_pc", bus_a.if_pc, 32'h0);
        for (int c = 0; c < 6; c++) tick();
        chk("ar_drained", 64'(exp_q.size()), 64'd0);

        // Wrap-around from the top of the address space.
        rst_nb = 1'b1;
        bus_b.if_ready = 1'b1;
        tick();
        chk("wrap_valid0", bus_b.if_valid, 1'b1);
        chk("wrap_pc0", bus_b.if_pc, 32'hFFFF_FFFC);
        chk("wrap_instr0", bus_b.if_instruction, 32'h1111_1111);
        tick();
        chk("wrap_pc1", bus_b.if_pc, 32'h0000_0000);
        chk("wrap_instr1", bus_b.if_instruction, 32'h2222_2222);
        tick();
        tick();
        chk("wrap_halted", bus_b.halted, 1'b1);
        chk("wrap_pc_hold", bus_b.PC, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
